seconds_bcd_display: RTL and testbench

Consumes the slow square wave from the lab's frequency divider (1 Hz from the 50 MHz board clock) and counts its rising edges in a 4-digit BCD counter. The counter is selectable up/down and can be paused and cleared. The block also time-multiplexes the four digits onto the board's common-anode seven-segment display. Everything runs in the single `clk` domain; the divider output is treated as a level to be edge-detected, never as a clock.

---
 rtl/seconds_bcd_display_if.sv | 27 ++
 rtl/seconds_bcd_display.sv | 134 +++++++++++++
 tb/tb_seconds_bcd_display.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seconds_bcd_display_if.sv
// seconds_bcd_display_if
//   Groups the slow-tick/control inputs and the count/display outputs of
//   seconds_bcd_display. Clock and reset stay plain ports on the module.
//   Signals:
//     tick_clk  slow square wave from the divider (level, edge-detected inside)
//     run       1 = count on tick edges, 0 = hold
//     up        1 = increment, 0 = decrement
//     clear     synchronous clear of the count
//     count     4-digit BCD value, [15:12] thousands .. [3:0] units
//     an        digit anodes, active-low, an[0] = units
//     seg       segments, active-low, {g,f,e,d,c,b,a}
//   master: drives tick_clk/run/up/clear (board or bench side)
//   slave : the counter/display block
interface seconds_bcd_display_if;
  logic        tick_clk;
  logic        run;
  logic        up;
  logic        clear;
  logic [15:0] count;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (output tick_clk, run, up, clear,
                  input  count, an, seg);
  modport slave  (input  tick_clk, run, up, clear,
                  output count, an, seg);
endinterface

// File: rtl/seconds_bcd_display.sv
// seconds_bcd_display
//   Counts rising edges of a slow square wave in a 4-digit BCD up/down
//   counter (pausable, clearable) and scans the digits onto a common-anode
//   seven-segment display. Single clock domain; tick_clk is a level.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    seconds_bcd_display_if.slave (tick_clk/run/up/clear in,
//            count/an/seg out)
//   Parameter:
//     REFRESH_DIV  clk cycles each digit is lit (>= 2)
//   Build option:
//     SEG_LEADING_ZERO_BLANK_EN  blank leading-zero thousands/hundreds/tens
//                                digits; units digit is always shown.
module seconds_bcd_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seconds_bcd_display_if.slave  bus
);

  localparam int              CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   LP_LAST = CW'(REFRESH_DIV - 1);

  logic          r_tick_d;
  logic [15:0]   r_count;
  logic [CW-1:0] r_refresh_cnt;
  logic [1:0]    r_sel;

  logic          w_step;
  logic [15:0]   w_inc;
  logic [15:0]   w_dec;
  logic          w_inc_c;
  logic          w_dec_b;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_blank;

  assign w_step = bus.tick_clk & ~r_tick_d;

  // BCD ripple increment/decrement; 9999 -> 0000 and 0000 -> 9999 fall out
  // naturally because the final carry/borrow is discarded.
  always_comb begin
    w_inc   = r_count;
    w_inc_c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_inc_c) begin
        if (r_count[i*4 +: 4] == 4'd9) begin
          w_inc[i*4 +: 4] = 4'd0;
        end else begin
          w_inc[i*4 +: 4] = r_count[i*4 +: 4] + 4'd1;
          w_inc_c         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_dec   = r_count;
    w_dec_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_dec_b) begin
        if (r_count[i*4 +: 4] == 4'd0) begin
          w_dec[i*4 +: 4] = 4'd9;
        end else begin
          w_dec[i*4 +: 4] = r_count[i*4 +: 4] - 4'd1;
          w_dec_b         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_d      <= 1'b1;  // a high tick at reset release is not an edge
      r_count       <= 16'h0000;
      r_refresh_cnt <= '0;
      r_sel         <= 2'd0;
    end else begin
      r_tick_d <= bus.tick_clk;

      if (bus.clear) begin
        r_count <= 16'h0000;
      end else if (w_step && bus.run) begin
        r_count <= bus.up ? w_inc : w_dec;
      end

      if (r_refresh_cnt == LP_LAST) begin
        r_refresh_cnt <= '0;
        r_sel         <= r_sel + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + CW'(1);
      end
    end
  end

  assign w_digit = r_count[{r_sel, 2'b00} +: 4];

  always_comb begin
    case (w_digit)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b1111111;
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every more-significant digit are 0.
  always_comb begin
    case (r_sel)
      2'd3:    w_blank = (r_count[15:12] == 4'd0);
      2'd2:    w_blank = (r_count[15:8]  == 8'd0);
      2'd1:    w_blank = (r_count[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  assign bus.count = r_count;
  assign bus.an    = ~(4'b0001 << r_sel);
  assign bus.seg   = w_blank ? 7'b1111111 : w_seg_dec;

endmodule

// File: tb/tb_seconds_bcd_display.sv
module tb_seconds_bcd_display;

  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic rst_n;

  seconds_bcd_display_if bus ();

  seconds_bcd_display #(.REFRESH_DIV(RDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] count;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  int    m_cyc    = 0;

  // cycles since reset release; drives the expected scan position
  always @(posedge clk) begin
    if (!rst_n) m_cyc <= 0;
    else        m_cyc <= m_cyc + 1;
  end

  function automatic logic [6:0] seg_model(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;  4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;  4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;  4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;  4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;  4'd9: s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  task automatic push_lit(input string nm, input logic [15:0] c,
                          input logic [3:0] a, input logic [6:0] s);
    exp_t e;
    e.count = c; e.an = a; e.seg = s;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic push_model(input string nm, input logic [15:0] c);
    int          pos;
    logic [3:0]  a;
    logic [6:0]  s;
    pos = (m_cyc / RDIV) % 4;
    a = 4'b1111;
    a[pos] = 1'b0;
    s = seg_model(4'((c >> (4 * pos)) & 16'hF));
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (pos > 0 && (c >> (4 * pos)) == 16'h0) s = 7'b1111111;
`endif
    push_lit(nm, c, a, s);
  endtask

  // monitor: every entry queued since the last edge describes the present state
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (bus.count !== e.count || bus.an !== e.an || bus.seg !== e.seg) begin
        n_err++;
        $display("FAIL %s: got count=%h an=%b seg=%b, want count=%h an=%b seg=%b",
                 nm, bus.count, bus.an, bus.seg, e.count, e.an, e.seg);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    bus.tick_clk = 1'b0; cyc();
    bus.tick_clk = 1'b1; cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic scan_model(input string nm, input logic [15:0] c);
    for (int i = 0; i < 4 * RDIV; i++) begin
      push_model(nm, c);
      cyc();
    end
  endtask

  task automatic align_scan();
    while (m_cyc % (4 * RDIV) != 0) cyc();
  endtask

  logic [3:0] an_tbl  [4];
  logic [6:0] s1234   [4];
  logic [6:0] s0007   [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    an_tbl[0] = 4'b1110; an_tbl[1] = 4'b1101; an_tbl[2] = 4'b1011; an_tbl[3] = 4'b0111;
    s1234[0] = 7'b0011001; s1234[1] = 7'b0110000; s1234[2] = 7'b0100100; s1234[3] = 7'b1111001;
    s0007[0] = 7'b1111000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    s0007[1] = 7'b1111111; s0007[2] = 7'b1111111; s0007[3] = 7'b1111111;
`else
    s0007[1] = 7'b1000000; s0007[2] = 7'b1000000; s0007[3] = 7'b1000000;
`endif

    rst_n = 1'b0;
    bus.tick_clk = 1'b1; bus.run = 1'b0; bus.up = 1'b1; bus.clear = 1'b0;
    cyc(); cyc(); cyc();
    push_lit("reset_state", 16'h0000, 4'b1110, 7'b1000000);
    rst_n = 1'b1; bus.run = 1'b1;
    cyc(); cyc(); cyc();
    push_model("high_at_release_not_counted", 16'h0000);
    cyc();

    tick();
    push_model("first_up_tick", 16'h0001);
    ticks(11);
    push_model("up_12", 16'h0012);
    ticks(87);
    push_model("up_0099", 16'h0099);
    tick();
    push_model("up_carry_0100", 16'h0100);
    scan_model("scan_0100", 16'h0100);

    bus.up = 1'b0;
    tick();
    push_model("down_borrow_0099", 16'h0099);
    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    push_model("clear_alone", 16'h0000);
    tick();
    push_model("down_wrap_9999", 16'h9999);
    bus.up = 1'b1;
    tick();
    push_model("up_wrap_0000", 16'h0000);

    ticks(3);
    push_model("up_0003", 16'h0003);
    bus.run = 1'b0;
    ticks(5);
    push_model("paused_0003", 16'h0003);
    bus.run = 1'b1;
    bus.tick_clk = 1'b0; cyc();
    bus.tick_clk = 1'b1; bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    push_model("clear_beats_step", 16'h0000);
    cyc();
    push_model("no_step_after_clear", 16'h0000);

    ticks(2);
    push_model("pre_reset_0002", 16'h0002);
    bus.tick_clk = 1'b0; cyc();
    rst_n = 1'b0; bus.tick_clk = 1'b1; cyc();
    push_lit("mid_count_reset", 16'h0000, 4'b1110, 7'b1000000);
    cyc();
    rst_n = 1'b1; cyc(); cyc();
    push_model("edge_in_reset_lost", 16'h0000);

    ticks(1234);
    push_model("up_1234", 16'h1234);
    align_scan();
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < RDIV; k++) begin
        push_lit("scan_1234", 16'h1234, an_tbl[d], s1234[d]);
        cyc();
      end

    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    ticks(7);
    align_scan();
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < RDIV; k++) begin
        push_lit("scan_0007", 16'h0007, an_tbl[d], s0007[d]);
        cyc();
      end
    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
    scan_model("scan_0000", 16'h0000);

    cyc(); cyc();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
